// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: decodes bits by high-pulse width, assembles
// 24-bit GRB pixels, tags each with its frame index and detects the latch gap.
`timescale 1ns/1ps

module ws2812_rx #(
    parameter int NUM_LEDS     = 256,
    parameter int BIT_THRESH   = 30,
    parameter int MIN_HIGH     = 5,
    parameter int MAX_HIGH     = 100,
    parameter int RESET_CYCLES = 2500
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic                        DI,
    output logic [23:0]                 PIX_DATA,
    output logic [$clog2(NUM_LEDS)-1:0] PIX_ADDR,
    output logic                        PIX_VALID,
    output logic                        FRAME_DONE,
    output logic [$clog2(NUM_LEDS):0]   PIX_COUNT,
    output logic                        OVERFLOW,
    output logic                        ERR
);

    localparam int AW = $clog2(NUM_LEDS);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(MAX_HIGH + 3);
    localparam int LW = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        HIGH
    } state_t;

    state_t          state_q, state_d;
    logic            di_meta_q, di_meta_d;
    logic            di_s_q, di_s_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [LW-1:0]   lcnt_q, lcnt_d;
    logic [23:0]     shift_q, shift_d;
    logic [4:0]      bitcnt_q, bitcnt_d;
    logic [CW-1:0]   pixcnt_q, pixcnt_d;
    logic            got_bit_q, got_bit_d;
    logic            ovf_clr_q, ovf_clr_d;
    logic            pend_q, pend_d;
    logic [23:0]     pix_data_q, pix_data_d;
    logic [AW-1:0]   pix_addr_q, pix_addr_d;
    logic            pix_valid_q, pix_valid_d;
    logic            frame_done_q, frame_done_d;
    logic [CW-1:0]   pix_count_q, pix_count_d;
    logic            overflow_q, overflow_d;
    logic            err_q, err_d;

    logic [LW-1:0]   lcnt_inc;
    logic [HW-1:0]   hcnt_inc;
    logic [HW-1:0]   hwidth;

    // Saturating counter increments and the high time measured so far
    // (the IDLE cycle that saw the rising edge counts as the first high cycle).
    always_comb begin
        lcnt_inc = (lcnt_q == LW'(RESET_CYCLES)) ? lcnt_q : lcnt_q + LW'(1);
        hcnt_inc = (hcnt_q == HW'(MAX_HIGH + 1)) ? hcnt_q : hcnt_q + HW'(1);
        hwidth   = hcnt_q + HW'(1);
    end

    // Next-state logic: synchronizer, pixel hand-off, and the SYNC/IDLE/HIGH decoder.
    always_comb begin
        state_d      = state_q;
        di_meta_d    = DI;
        di_s_d       = di_meta_q;
        hcnt_d       = hcnt_q;
        lcnt_d       = lcnt_q;
        shift_d      = shift_q;
        bitcnt_d     = bitcnt_q;
        pixcnt_d     = pixcnt_q;
        got_bit_d    = got_bit_q;
        ovf_clr_d    = ovf_clr_q;
        pend_d       = 1'b0;
        pix_data_d   = pix_data_q;
        pix_addr_d   = pix_addr_q;
        pix_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        pix_count_d  = pix_count_q;
        overflow_d   = overflow_q;
        err_d        = 1'b0;

        if (pend_q) begin
            if (pixcnt_q >= CW'(NUM_LEDS)) begin
                overflow_d = 1'b1;
            end else begin
                pix_valid_d = 1'b1;
                pix_data_d  = shift_q;
                pix_addr_d  = pixcnt_q[AW-1:0];
                pixcnt_d    = pixcnt_q + CW'(1);
            end
        end

        case (state_q)
            SYNC: begin
                if (di_s_q) begin
                    lcnt_d = '0;
                end else begin
                    lcnt_d = lcnt_inc;
                    if (lcnt_inc == LW'(RESET_CYCLES)) begin
                        state_d    = IDLE;
                        bitcnt_d   = '0;
                        pixcnt_d   = '0;
                        overflow_d = 1'b0;
                        got_bit_d  = 1'b0;
                        ovf_clr_d  = 1'b0;
                    end
                end
            end
            IDLE: begin
                if (di_s_q) begin
                    hcnt_d  = '0;
                    state_d = HIGH;
                end else begin
                    lcnt_d = lcnt_inc;
                    if (lcnt_inc == LW'(RESET_CYCLES) && got_bit_q) begin
                        frame_done_d = 1'b1;
                        pix_count_d  = (pixcnt_q > CW'(NUM_LEDS)) ? CW'(NUM_LEDS) : pixcnt_q;
                        err_d        = (bitcnt_q != 5'd0);
                        bitcnt_d     = '0;
                        pixcnt_d     = '0;
                        got_bit_d    = 1'b0;
                        ovf_clr_d    = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (di_s_q) begin
                    hcnt_d = hcnt_inc;
                    if (hwidth >= HW'(MAX_HIGH)) begin
                        err_d    = 1'b1;
                        state_d  = SYNC;
                        lcnt_d   = '0;
                        bitcnt_d = '0;
                        shift_d  = '0;
                    end
                end else if (hwidth < HW'(MIN_HIGH)) begin
                    state_d = IDLE;
                end else begin
                    shift_d   = {shift_q[22:0], (hwidth >= HW'(BIT_THRESH))};
                    lcnt_d    = '0;
                    state_d   = IDLE;
                    got_bit_d = 1'b1;
                    if (ovf_clr_q) begin
                        overflow_d = 1'b0;
                        ovf_clr_d  = 1'b0;
                    end
                    if (bitcnt_q == 5'd23) begin
                        bitcnt_d = '0;
                        pend_d   = 1'b1;
                    end else begin
                        bitcnt_d = bitcnt_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = SYNC;
            end
        endcase
    end

    // State and output registers with synchronous reset back to SYNC.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= SYNC;
            di_meta_q    <= 1'b0;
            di_s_q       <= 1'b0;
            hcnt_q       <= '0;
            lcnt_q       <= '0;
            shift_q      <= '0;
            bitcnt_q     <= '0;
            pixcnt_q     <= '0;
            got_bit_q    <= 1'b0;
            ovf_clr_q    <= 1'b0;
            pend_q       <= 1'b0;
            pix_data_q   <= '0;
            pix_addr_q   <= '0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pix_count_q  <= '0;
            overflow_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            di_meta_q    <= di_meta_d;
            di_s_q       <= di_s_d;
            hcnt_q       <= hcnt_d;
            lcnt_q       <= lcnt_d;
            shift_q      <= shift_d;
            bitcnt_q     <= bitcnt_d;
            pixcnt_q     <= pixcnt_d;
            got_bit_q    <= got_bit_d;
            ovf_clr_q    <= ovf_clr_d;
            pend_q       <= pend_d;
            pix_data_q   <= pix_data_d;
            pix_addr_q   <= pix_addr_d;
            pix_valid_q  <= pix_valid_d;
            frame_done_q <= frame_done_d;
            pix_count_q  <= pix_count_d;
            overflow_q   <= overflow_d;
            err_q        <= err_d;
        end
    end

    assign PIX_DATA   = pix_data_q;
    assign PIX_ADDR   = pix_addr_q;
    assign PIX_VALID  = pix_valid_q;
    assign FRAME_DONE = frame_done_q;
    assign PIX_COUNT  = pix_count_q;
    assign OVERFLOW   = overflow_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: a default-size receiver and a 4-LED receiver.
`timescale 1ns/1ps

module tb_ws2812_rx;

    logic clk;
    logic reset;
    logic di_drv;
    int   sel;
    logic di_main;
    logic di_small;

    logic [23:0] pix_data;
    logic [7:0]  pix_addr;
    logic        pix_valid;
    logic        frame_done;
    logic [8:0]  pix_count;
    logic        overflow;
    logic        err;

    logic [23:0] pix_data4;
    logic [1:0]  pix_addr4;
    logic        pix_valid4;
    logic        frame_done4;
    logic [2:0]  pix_count4;
    logic        overflow4;
    logic        err4;

    int vectors;
    int miscompares;

    logic [23:0] vdata[$];
    logic [7:0]  vaddr[$];
    time         vlat[$];
    time         vtime[$];
    int          fd_cnt;
    int          err_cnt;
    time         fd_time;
    time         err_time;
    time         last_fall;

    logic [23:0] vdata4[$];
    logic [1:0]  vaddr4[$];
    int          fd_cnt4;
    int          err_cnt4;

    assign di_main  = (sel == 0) ? di_drv : 1'b0;
    assign di_small = (sel == 1) ? di_drv : 1'b0;

    ws2812_rx dut (
        .CLK(clk), .RESET(reset), .DI(di_main),
        .PIX_DATA(pix_data), .PIX_ADDR(pix_addr), .PIX_VALID(pix_valid),
        .FRAME_DONE(frame_done), .PIX_COUNT(pix_count), .OVERFLOW(overflow), .ERR(err)
    );

    ws2812_rx #(.NUM_LEDS(4)) dut4 (
        .CLK(clk), .RESET(reset), .DI(di_small),
        .PIX_DATA(pix_data4), .PIX_ADDR(pix_addr4), .PIX_VALID(pix_valid4),
        .FRAME_DONE(frame_done4), .PIX_COUNT(pix_count4), .OVERFLOW(overflow4), .ERR(err4)
    );

    // 100 MHz bench clock; DUT cycle counts are what matter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record strobes of the default-size receiver on the falling edge.
    always @(negedge clk) begin
        if (pix_valid) begin
            vdata.push_back(pix_data);
            vaddr.push_back(pix_addr);
            vlat.push_back($time - last_fall);
            vtime.push_back($time);
        end
        if (frame_done) begin
            fd_cnt++;
            fd_time = $time;
        end
        if (err) begin
            err_cnt++;
            err_time = $time;
        end
    end

    // Record strobes of the 4-LED receiver on the falling edge.
    always @(negedge clk) begin
        if (pix_valid4) begin
            vdata4.push_back(pix_data4);
            vaddr4.push_back(pix_addr4);
        end
        if (frame_done4) fd_cnt4++;
        if (err4) err_cnt4++;
    end

    task automatic hold_low(input int n);
        di_drv = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        di_drv = 1'b1;
        repeat (b ? 40 : 20) @(negedge clk);
        di_drv = 1'b0;
        last_fall = $time;
        repeat (b ? 22 : 42) @(negedge clk);
    endtask

    task automatic send_pixel(input logic [23:0] p);
        for (int i = 23; i >= 0; i--) send_bit(p[i]);
    endtask

    task automatic test_reset;
        vectors++;
        if (pix_data !== 24'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_pix_data: got %h expected 000000", pix_data);
        end
        vectors++;
        if (pix_valid !== 1'b0 || frame_done !== 1'b0 || err !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_strobes: got v=%b fd=%b err=%b ovf=%b expected all 0",
                     pix_valid, frame_done, err, overflow);
        end
        vectors++;
        if (pix_count !== 9'd0 || pix_addr !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_count_addr: got count=%0d addr=%0d expected 0/0", pix_count, pix_addr);
        end
    endtask

    task automatic test_single_pixel;
        int fd0, e0;
        vdata.delete(); vaddr.delete(); vlat.delete(); vtime.delete();
        fd0 = fd_cnt; e0 = err_cnt;
        send_pixel(24'h123456);
        hold_low(3000);
        vectors++;
        if (vdata.size() !== 1) begin
            miscompares++;
            $display("[TB] FAIL single_valid_count: got %0d expected 1", vdata.size());
        end
        if (vdata.size() >= 1) begin
            vectors++;
            if (vdata[0] !== 24'h123456) begin
                miscompares++;
                $display("[TB] FAIL single_data: got %h expected 123456", vdata[0]);
            end
            vectors++;
            if (vaddr[0] !== 8'd0) begin
                miscompares++;
                $display("[TB] FAIL single_addr: got %0d expected 0", vaddr[0]);
            end
            vectors++;
            if (vlat[0] !== 64'd40) begin
                miscompares++;
                $display("[TB] FAIL single_latency: got %0t expected 40 ns", vlat[0]);
            end
            vectors++;
            if (!(vtime[0] < fd_time)) begin
                miscompares++;
                $display("[TB] FAIL single_order: got valid@%0t done@%0t expected valid first", vtime[0], fd_time);
            end
        end
        vectors++;
        if (fd_cnt - fd0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL single_frame_done: got %0d expected 1", fd_cnt - fd0);
        end
        vectors++;
        if (pix_count !== 9'd1) begin
            miscompares++;
            $display("[TB] FAIL single_pix_count: got %0d expected 1", pix_count);
        end
        vectors++;
        if (err_cnt - e0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL single_err: got %0d expected 0", err_cnt - e0);
        end
    endtask

    task automatic test_three_pixels;
        int fd0, e0;
        logic [23:0] exp_px[3];
        exp_px[0] = 24'hFF0000; exp_px[1] = 24'h00FF00; exp_px[2] = 24'h0000FF;
        vdata.delete(); vaddr.delete(); vlat.delete(); vtime.delete();
        fd0 = fd_cnt; e0 = err_cnt;
        for (int i = 0; i < 3; i++) send_pixel(exp_px[i]);
        hold_low(2600);
        vectors++;
        if (vdata.size() !== 3) begin
            miscompares++;
            $display("[TB] FAIL three_valid_count: got %0d expected 3", vdata.size());
        end
        for (int i = 0; i < 3 && i < vdata.size(); i++) begin
            vectors++;
            if (vdata[i] !== exp_px[i] || vaddr[i] !== 8'(i)) begin
                miscompares++;
                $display("[TB] FAIL three_pixel_%0d: got %h@%0d expected %h@%0d", i, vdata[i], vaddr[i], exp_px[i], i);
            end
        end
        vectors++;
        if (pix_count !== 9'd3 || fd_cnt - fd0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL three_count: got count=%0d done=%0d expected 3/1", pix_count, fd_cnt - fd0);
        end
        vectors++;
        if (err_cnt - e0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL three_err: got %0d expected 0", err_cnt - e0);
        end
    endtask

    task automatic test_overflow;
        int fd0;
        vdata4.delete(); vaddr4.delete();
        fd0 = fd_cnt4;
        sel = 1;
        for (int i = 1; i <= 6; i++) send_pixel(24'(i));
        hold_low(2600);
        vectors++;
        if (vdata4.size() !== 4) begin
            miscompares++;
            $display("[TB] FAIL ovf_valid_count: got %0d expected 4", vdata4.size());
        end
        for (int i = 0; i < 4 && i < vdata4.size(); i++) begin
            vectors++;
            if (vdata4[i] !== 24'(i + 1) || vaddr4[i] !== 2'(i)) begin
                miscompares++;
                $display("[TB] FAIL ovf_pixel_%0d: got %h@%0d expected %h@%0d", i, vdata4[i], vaddr4[i], i + 1, i);
            end
        end
        vectors++;
        if (overflow4 !== 1'b1 || pix_count4 !== 3'd4 || fd_cnt4 - fd0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL ovf_after_latch: got ovf=%b count=%0d done=%0d expected 1/4/1",
                     overflow4, pix_count4, fd_cnt4 - fd0);
        end
        send_bit(1'b1);
        vectors++;
        if (overflow4 !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL ovf_clear_first_bit: got %b expected 0", overflow4);
        end
        hold_low(10);
        sel = 0;
    endtask

    task automatic test_partial_frame;
        int fd0, e0;
        vdata.delete(); vaddr.delete(); vlat.delete(); vtime.delete();
        fd0 = fd_cnt; e0 = err_cnt;
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        hold_low(2600);
        vectors++;
        if (err_cnt - e0 !== 1 || fd_cnt - fd0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL partial_strobes: got err=%0d done=%0d expected 1/1", err_cnt - e0, fd_cnt - fd0);
        end
        vectors++;
        if (err_time !== fd_time) begin
            miscompares++;
            $display("[TB] FAIL partial_same_cycle: got err@%0t done@%0t expected equal", err_time, fd_time);
        end
        vectors++;
        if (pix_count !== 9'd0 || vdata.size() !== 0) begin
            miscompares++;
            $display("[TB] FAIL partial_count: got count=%0d valids=%0d expected 0/0", pix_count, vdata.size());
        end
    endtask

    task automatic test_glitch;
        int e0;
        logic [23:0] px;
        px = 24'hA5C3E1;
        vdata.delete(); vaddr.delete(); vlat.delete(); vtime.delete();
        e0 = err_cnt;
        for (int i = 23; i >= 0; i--) begin
            send_bit(px[i]);
            if (i == 12) begin
                di_drv = 1'b1;
                repeat (3) @(negedge clk);
                hold_low(30);
            end
        end
        hold_low(2600);
        vectors++;
        if (vdata.size() !== 1 || (vdata.size() == 1 && vdata[0] !== 24'hA5C3E1)) begin
            miscompares++;
            $display("[TB] FAIL glitch_data: got n=%0d first=%h expected 1 x a5c3e1",
                     vdata.size(), (vdata.size() > 0) ? vdata[0] : 24'h0);
        end
        vectors++;
        if (err_cnt - e0 !== 0 || pix_count !== 9'd1) begin
            miscompares++;
            $display("[TB] FAIL glitch_err_count: got err=%0d count=%0d expected 0/1", err_cnt - e0, pix_count);
        end
    endtask

    task automatic test_stuck_high;
        int fd0, e0;
        vdata.delete(); vaddr.delete(); vlat.delete(); vtime.delete();
        fd0 = fd_cnt; e0 = err_cnt;
        di_drv = 1'b1;
        repeat (150) @(negedge clk);
        hold_low(30);
        send_pixel(24'hFFFFFF);
        hold_low(300);
        vectors++;
        if (err_cnt - e0 !== 1 || vdata.size() !== 0 || fd_cnt - fd0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL stuck_no_decode: got err=%0d valids=%0d done=%0d expected 1/0/0",
                     err_cnt - e0, vdata.size(), fd_cnt - fd0);
        end
        hold_low(2600);
        send_pixel(24'h0F0F0F);
        hold_low(2600);
        vectors++;
        if (vdata.size() !== 1 || (vdata.size() == 1 && (vdata[0] !== 24'h0F0F0F || vaddr[0] !== 8'd0))) begin
            miscompares++;
            $display("[TB] FAIL stuck_recover: got n=%0d expected one 0f0f0f@0", vdata.size());
        end
        vectors++;
        if (err_cnt - e0 !== 1 || fd_cnt - fd0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL stuck_totals: got err=%0d done=%0d expected 1/1", err_cnt - e0, fd_cnt - fd0);
        end
    endtask

    task automatic test_reset_mid_pixel;
        int fd0;
        logic [23:0] px;
        px = 24'h00AA55;
        vdata.delete(); vaddr.delete(); vlat.delete(); vtime.delete();
        fd0 = fd_cnt;
        for (int i = 23; i >= 12; i--) send_bit(px[i]);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (pix_count !== 9'd0 || pix_data !== 24'h0 || pix_addr !== 8'd0 || overflow !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_outputs: got count=%0d data=%h addr=%0d ovf=%b expected zeros",
                     pix_count, pix_data, pix_addr, overflow);
        end
        for (int i = 11; i >= 0; i--) send_bit(px[i]);
        send_pixel(px);
        hold_low(300);
        vectors++;
        if (vdata.size() !== 0 || fd_cnt - fd0 !== 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_ignored: got valids=%0d done=%0d expected 0/0", vdata.size(), fd_cnt - fd0);
        end
        hold_low(2600);
        send_pixel(px);
        hold_low(2600);
        vectors++;
        if (vdata.size() !== 1 || (vdata.size() == 1 && vdata[0] !== 24'h00AA55) || fd_cnt - fd0 !== 1) begin
            miscompares++;
            $display("[TB] FAIL midreset_resync: got valids=%0d done=%0d expected one 00aa55 and 1 frame",
                     vdata.size(), fd_cnt - fd0);
        end
    endtask

    // Test sequence.
    initial begin
        vectors = 0; miscompares = 0;
        fd_cnt = 0; err_cnt = 0; fd_time = 0; err_time = 0; last_fall = 0;
        fd_cnt4 = 0; err_cnt4 = 0;
        sel = 0;
        di_drv = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        test_reset;
        reset = 1'b0;
        hold_low(2600);
        $display("[TB] single pixel");
        test_single_pixel;
        $display("[TB] three pixels");
        test_three_pixels;
        $display("[TB] overflow on 4-LED receiver");
        test_overflow;
        $display("[TB] partial frame");
        test_partial_frame;
        $display("[TB] glitch");
        test_glitch;
        $display("[TB] stuck high");
        test_stuck_high;
        $display("[TB] reset mid pixel");
        test_reset_mid_pixel;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ws2812_rx.md
Name: ws2812_rx

Overview:
- Receives a WS2812 single-wire data stream on DI and decodes each bit by its high-pulse width.
- Assembles decoded bits into 24-bit GRB pixels and presents each pixel with its LED address as a one-cycle valid pulse.
- Detects the latch (reset) gap and signals frame completion.
- This is the receiving end of the ws2812 transmitter chain. It is used for loopback verification of the SPI-to-neopixel path, and as the front end for a future daisy-chained FPGA pixel node.

Parameters:
- NUM_LEDS, 256: maximum pixels stored per frame; sets the PIX_ADDR width to $clog2(NUM_LEDS).
- BIT_THRESH, 30: high-time threshold in CLK cycles (0.6 us at 50 MHz). High count >= BIT_THRESH decodes as 1, otherwise 0.
- MIN_HIGH, 5: high pulses shorter than this count (in cycles) are glitches and are ignored.
- MAX_HIGH, 100: high pulses longer than this count (in cycles) are an error.
- RESET_CYCLES, 2500: low time that constitutes latch/reset (50 us at 50 MHz).

Ports:
- CLK  in  1  system clock (50 MHz nominal)
- RESET  in  1  synchronous, active-high reset
- DI  in  1  asynchronous WS2812 data input
- PIX_DATA  out  24  decoded pixel; first-received bit is bit 23; order is G[23:16] R[15:8] B[7:0]
- PIX_ADDR  out  $clog2(NUM_LEDS)  index of PIX_DATA within the current frame
- PIX_VALID  out  1  one-cycle strobe; PIX_DATA and PIX_ADDR are valid while it is high
- FRAME_DONE  out  1  one-cycle strobe at latch detection when the frame received at least one bit
- PIX_COUNT  out  $clog2(NUM_LEDS)+1  complete pixels in the last finished frame; held until the next FRAME_DONE
- OVERFLOW  out  1  sticky per frame: more than NUM_LEDS pixels were received
- ERR  out  1  one-cycle strobe on a framing error

Behaviour:
- Synchronizer:
  - DI passes through a 2-flop synchronizer to di_s. All timing below refers to di_s.
  - Added latency is 2 CLK.
- Reset values: every output is 0; internal counters are 0; state is SYNC.
- Counters:
  - hcnt counts high cycles and saturates at MAX_HIGH+1.
  - lcnt counts low cycles and saturates at RESET_CYCLES.
  - shift holds 24 bits; bitcnt is 0..23; pixcnt is $clog2(NUM_LEDS)+1 bits.
- State SYNC:
  - Waits for a clean gap; bits are never decoded here.
  - di_s low: lcnt increments. di_s high: lcnt clears.
  - When lcnt reaches RESET_CYCLES: go to IDLE; clear bitcnt, pixcnt, OVERFLOW.
- State IDLE:
  - Line is low between bits or between frames.
  - di_s high: clear hcnt, go to HIGH.
  - Otherwise lcnt increments. When lcnt reaches RESET_CYCLES and the frame has received any bit:
    - Pulse FRAME_DONE.
    - Load PIX_COUNT with min(pixcnt, NUM_LEDS).
    - If bitcnt != 0, also pulse ERR (partial pixel discarded).
    - Clear bitcnt, pixcnt; clear OVERFLOW on the next frame's first bit.
- State HIGH:
  - hcnt increments each cycle.
  - If hcnt exceeds MAX_HIGH: pulse ERR, discard the partial pixel, go to SYNC.
  - On di_s low with hcnt < MIN_HIGH: glitch; return to IDLE without decoding. lcnt is not cleared.
  - On di_s low otherwise:
    - Decode bit = (hcnt >= BIT_THRESH) and shift it in MSB-first.
    - Clear lcnt; go to IDLE.
    - If bitcnt was 23: the next cycle drives PIX_VALID=1, PIX_DATA=shift, PIX_ADDR=pixcnt, then pixcnt increments and bitcnt wraps to 0.
- Latency: a DI falling edge that completes pixel N gives PIX_VALID high 3 CLK after the first CLK edge that samples DI low.
- Overflow:
  - When pixcnt >= NUM_LEDS, completed pixels raise OVERFLOW and do not pulse PIX_VALID.
  - pixcnt saturates at NUM_LEDS. PIX_ADDR therefore never wraps.
- Simultaneous events:
  - The frame's last pixel completing, then latch 2500 cycles later: PIX_VALID always precedes FRAME_DONE. They never coincide.
  - RESET asserted in any state wins: outputs clear the same cycle and the block re-enters SYNC. A frame in progress is lost and the block must resynchronize on a full gap.
- DI stuck high: ERR pulses once, then the block stays in SYNC until a full low gap.

Test Plan:
- After RESET, hold DI low 2500 cycles, then send 24 bits of 0x12_34_56 (0 = 20 high/42 low cycles, 1 = 40 high/22 low) and 60 us low -> one PIX_VALID with PIX_DATA=0x123456, PIX_ADDR=0; then FRAME_DONE; PIX_COUNT=1.
- After a gap, send 3 pixels 0xFF0000, 0x00FF00, 0x0000FF, then latch -> PIX_ADDR 0,1,2 with matching data; PIX_COUNT=3; ERR never asserts.
- Instantiate with NUM_LEDS=4 and send 6 pixels -> exactly 4 PIX_VALID pulses; OVERFLOW=1; PIX_COUNT=4; the next frame's first bit clears OVERFLOW.
- Send 10 bits, then latch -> ERR pulse and FRAME_DONE in the same cycle; PIX_COUNT=0; no PIX_VALID.
- Inject a 3-cycle high glitch mid-frame, and separately hold DI high for 150 cycles -> the glitch does not change decoded data; the long high gives one ERR and no PIX_VALID until a 2500-cycle gap plus a fresh pixel.
- Assert RESET for 1 cycle at bit 12 of a pixel -> outputs return to 0; bits sent without a preceding 2500-cycle gap are ignored.
